// File: rtl/opc5ls_uart_pkg.sv
// Shared constants, register map and FSM state types for the OPC5LS UART.
// No logic; imported by the UART top and its FIFO.
package opc5ls_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQEN  = 2'd3;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_FRAME_ERR = 5;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/opc5ls_uart_fifo.sv
// Synchronous FIFO, power-of-2 depth; pop data is visible combinationally at the head.
// Pushes while full and pops while empty are ignored; the caller gates them.
module opc5ls_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_pop_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/opc5ls_uart.sv
// Memory-mapped 8N1 UART: combinational reads, writes land on the clock edge; full TX FIFO drops bytes.
// Define OPC5LS_UART_IRQ_EN to add the registered irq output and the IRQEN register at offset 3.
module opc5ls_uart
  import opc5ls_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFE00,
  parameter logic [15:0] CLK_DIV      = 16'd217,
  parameter int          TXFIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] address,
  input  logic [15:0] dout,
  input  logic        rnw,
  output logic        io_sel,
  output logic [15:0] io_rdata,
  output logic        txd,
  input  logic        rxd
`ifdef OPC5LS_UART_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int CW = $clog2(TXFIFO_DEPTH) + 1;

  logic          w_wr, w_wr_data, w_wr_status, w_wr_div, w_rx_pop;
  logic [15:0]   r_div, w_div_eff, w_div_m1;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid, r_rx_ovr, r_tx_ovf, r_frame_err;
  logic          w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty, w_tx_idle;
  logic [7:0]    w_fifo_dat;
  logic [CW-1:0] w_fifo_count;

  assign io_sel      = (address[15:2] == BASE_ADDR[15:2]);
  assign w_wr        = io_sel & ~rnw;
  assign w_wr_data   = w_wr & (address[1:0] == REG_DATA);
  assign w_wr_status = w_wr & (address[1:0] == REG_STATUS);
  assign w_wr_div    = w_wr & (address[1:0] == REG_DIV);
  assign w_rx_pop    = w_wr_status & dout[ST_RX_VALID];
  assign w_div_eff   = eff_div(r_div);
  assign w_div_m1    = w_div_eff - 16'd1;
  assign w_fifo_push = w_wr_data & ~w_fifo_full;

  opc5ls_uart_fifo #(.WIDTH(8), .DEPTH(TXFIFO_DEPTH)) u_txfifo (
    .clk        (clk),
    .reset_b    (reset_b),
    .i_push     (w_fifo_push),
    .i_push_dat (dout[7:0]),
    .i_pop      (w_fifo_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  // ---------------- TX ----------------
  tx_state_t   r_tx_state, w_tx_next;
  logic [15:0] r_tx_timer;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd, w_tx_tick, w_tx_load;

  assign w_tx_tick  = (r_tx_timer == 16'd0);
  assign w_fifo_pop = w_tx_load;
  assign w_tx_idle  = (w_fifo_count == '0) & (r_tx_state == TX_IDLE);
  assign txd        = r_txd;

  always_ff @(posedge clk) begin
    if (!reset_b) r_tx_state <= TX_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (!w_fifo_empty) begin
                  w_tx_next = TX_START;
                  w_tx_load = 1'b1;
                end
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick) begin
                  // Chain straight into the next start bit so back-to-back frames have no gap.
                  w_tx_next = w_fifo_empty ? TX_IDLE : TX_START;
                  w_tx_load = ~w_fifo_empty;
                end
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_tx_timer <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else if (w_tx_load) begin
      r_tx_shift <= w_fifo_dat;
      r_txd      <= 1'b0;
      r_tx_timer <= w_div_m1;
    end else if (r_tx_state != TX_IDLE) begin
      if (w_tx_tick) begin
        r_tx_timer <= w_div_m1;
        case (r_tx_state)
          TX_START: begin
            r_txd    <= r_tx_shift[0];
            r_tx_bit <= '0;
          end
          TX_DATA: begin
            if (r_tx_bit == 3'd7) begin
              r_txd <= 1'b1;
            end else begin
              r_txd      <= r_tx_shift[1];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end
          default: r_txd <= 1'b1;
        endcase
      end else begin
        r_tx_timer <= r_tx_timer - 16'd1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t   r_rx_state, w_rx_next;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [15:0] r_rx_timer;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_tick, w_rx_done;

  assign w_rx_tick = (r_rx_timer == 16'd0);
  assign w_rx_done = (r_rx_state == RX_STOP) & w_rx_tick;

  always_ff @(posedge clk) begin
    if (!reset_b) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev & ~r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_timer <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      // Idle keeps the half-bit delay preloaded so START begins counting on the edge it is entered.
      if (r_rx_state == RX_IDLE) begin
        r_rx_timer <= {1'b0, w_div_eff[15:1]} - 16'd1;
      end else if (w_rx_tick) begin
        r_rx_timer <= w_div_m1;
        if (r_rx_state == RX_START) r_rx_bit <= '0;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_timer <= r_rx_timer - 16'd1;
      end
    end
  end

  // ---------------- registers and flags ----------------
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_div       <= CLK_DIV;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= dout;
      r_tx_ovf    <= (r_tx_ovf & ~(w_wr_status & dout[ST_TX_OVF])) | (w_wr_data & w_fifo_full);
      r_rx_ovr    <= (r_rx_ovr & ~(w_wr_status & dout[ST_RX_OVR]))
                   | (w_rx_done & r_rx_s2 & r_rx_valid & ~w_rx_pop);
      r_frame_err <= (r_frame_err & ~(w_wr_status & dout[ST_FRAME_ERR])) | (w_rx_done & ~r_rx_s2);
      // A pop in the same cycle as a good stop bit frees the holding register for the new byte.
      if (w_rx_done & r_rx_s2 & (~r_rx_valid | w_rx_pop)) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef OPC5LS_UART_IRQ_EN
  logic [1:0] r_irqen;
  logic       r_irq;

  assign irq = r_irq;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_irqen <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr & (address[1:0] == REG_IRQEN)) r_irqen <= dout[1:0];
      r_irq <= (r_rx_valid & r_irqen[0]) | (w_tx_idle & r_irqen[1]);
    end
  end
`endif

  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      case (address[1:0])
        REG_DATA:   io_rdata = {8'h00, r_rx_data};
        REG_STATUS: begin
          io_rdata[ST_RX_VALID]  = r_rx_valid;
          io_rdata[ST_TX_FULL]   = w_fifo_full;
          io_rdata[ST_TX_IDLE]   = w_tx_idle;
          io_rdata[ST_RX_OVR]    = r_rx_ovr;
          io_rdata[ST_TX_OVF]    = r_tx_ovf;
          io_rdata[ST_FRAME_ERR] = r_frame_err;
        end
        REG_DIV:    io_rdata = r_div;
        default: begin
`ifdef OPC5LS_UART_IRQ_EN
          io_rdata = {14'b0, r_irqen};
`else
          io_rdata = '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: doc/opc5ls_uart.md
Name: opc5ls_uart

Overview:
- Memory-mapped 8N1 UART on the OPC5LS CPU bus, directly downstream of the CPU core.
- Consumes the core's address/dout/rnw outputs and returns read data, which top-level muxes onto the core's din when io_sel is high.
- Provides a TX FIFO and a single-byte RX holding register.
- RX pop is an explicit register write, never a read side effect, because the core drives fetch addresses with rnw=1 every cycle.

Parameters:
- BASE_ADDR, 16'hFE00, word address of register 0; bits [1:0] must be 0.
- CLK_DIV, 16'd217, reset value of the divisor (clocks per bit).
- TXFIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  in  16  core address bus.
- dout  in  16  core write data.
- rnw  in  1  core read-not-write; 0 means a write this cycle.
- io_sel  out  1  combinational: address[15:2]==BASE_ADDR[15:2].
- io_rdata  out  16  combinational read data for the selected register; 0 when io_sel=0.
- txd  out  1  serial transmit; idles high.
- rxd  in  1  serial receive; asynchronous to clk.

Behaviour:
- Register map, offset address[1:0]:
  - 0 DATA
    - Read: {8'b0, rx_data}.
    - Write: push dout[7:0] to the TX FIFO.
    - If the FIFO is full (registered count==DEPTH, even if the shifter pops in the same cycle), the byte is dropped and tx_ovf is set.
  - 1 STATUS
    - Read bits: [0] rx_valid, [1] tx_full, [2] tx_idle (FIFO empty and TX FSM in IDLE), [3] rx_ovr, [4] tx_ovf, [5] frame_err; other bits 0.
    - Write: dout[0]=1 clears rx_valid (pop).
    - Write: dout[5:3] are write-1-to-clear for the sticky flags.
  - 2 DIV
    - Read/write 16-bit divisor.
    - Any value <2 is treated as 2.
    - A new value takes effect at the next bit boundary.
  - 3 reserved; reads 0, writes ignored.
- Writes are effective when io_sel & !rnw at the rising edge. There is no write latency visible to the core.
- Reset values:
  - txd=1; io_rdata follows its combinational rule.
  - FIFO empty; rx_data=0.
  - All flags 0; divisor=CLK_DIV.
  - Both FSMs in IDLE.
  - Reset mid-frame aborts the frame immediately and drives txd=1 on the next cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is non-empty, pop into the shifter and go to START with txd=0.
  - Each state holds for exactly divisor clocks. A bit timer loads divisor-1 and counts to 0.
  - DATA sends 8 bits, LSB first. STOP drives txd=1.
  - From STOP, go to IDLE, or directly to START when the FIFO is non-empty (back-to-back frames have no idle gap).
- RX:
  - rxd passes through a 2-flop synchronizer.
  - IDLE: a falling edge enters START and waits divisor/2 clocks.
    - If the line is low, go to DATA.
    - If high, treat as a glitch and return to IDLE.
  - DATA samples 8 bits, each divisor clocks apart, LSB first.
  - STOP samples once after divisor clocks:
    - Stop bit high and rx_valid=0: load rx_data and set rx_valid.
    - Stop bit high and rx_valid=1: discard the new byte and set rx_ovr.
    - Stop bit low: discard the byte and set frame_err.
    - In all cases return to IDLE.
- Simultaneous events:
  - Pop write in the same cycle a byte completes: the new byte is loaded, rx_valid stays 1, and rx_ovr is not set.
  - Flag set and W1C in the same cycle: set wins.

Optional Feature:
- Macro: OPC5LS_UART_IRQ_EN.
- When defined:
  - Adds output irq (1 bit, registered, reset 0).
  - Offset 3 becomes IRQEN (read/write bits [1:0], reset 0).
  - irq <= (rx_valid & en[0]) | (tx_idle & en[1]).
- When undefined: there is no irq port, and offset 3 reads 0.

Decomposition:
- Package opc5ls_uart_pkg holds:
  - Register offset constants.
  - STATUS bit position constants.
  - TX and RX FSM state enums.
  - The minimum-divisor constant (2).
- One sub-module, opc5ls_uart_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on width and depth, same clk/reset_b.

Test Plan:
- Reset, DIV=4, write DATA=16'h00A5 → txd low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4 clocks; STATUS[2] returns to 1.
- Push 9 bytes with DEPTH=8 while the shifter is idle-blocked (push in consecutive cycles) → first byte enters the shifter, the next 8 fill the FIFO, no overflow; a 10th push sets tx_ovf (STATUS=16'h0012 while full).
- Drive an RX frame of 8'h3C at DIV=4 → rx_valid=1, DATA reads 16'h003C; write STATUS=16'h0001 → rx_valid=0.
- Two RX frames with no pop → second byte discarded, rx_data=8'h3C, rx_ovr=1; W1C 16'h0008 clears it.
- Stop bit driven low → frame_err=1, rx_valid unchanged; a 1-clock low glitch on rxd → no frame started.
- OPC5LS_UART_IRQ_EN defined: IRQEN=2'b01 and a byte received → irq=1 one clock after rx_valid rises; pop → irq=0 one clock later.
